shift_arbiter2: RTL and testbench
=================================

SHIFT_ARBITER2 -- requirements
Module: shift_arbiter2

Interface
REQ-001 SHALL have parameter RR_EN, default 1, arbitration mode: 1 = round-robin, 0 = fixed priority with req0 winning.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port req0_valid, input, 1 bit, requester 0 has an operation pending.
REQ-005 SHALL have port req0_data, input, 8 bits, requester 0 operand.
REQ-006 SHALL have port req0_amt, input, 3 bits, requester 0 right-shift amount (0..7).
REQ-007 SHALL have port req0_ready, output, 1 bit, requester 0 operation accepted this cycle.
REQ-008 SHALL have ports req1_valid, req1_data, req1_amt and req1_ready, with the same directions, widths and meanings for requester 1.
REQ-009 SHALL have port res_valid, output, 1 bit, result register holds a valid result.
REQ-010 SHALL have port res_data, output, 8 bits, shifted result.
REQ-011 SHALL have port res_id, output, 1 bit, index of the requester that owns res_data.
REQ-012 SHALL have port res_ready, input, 1 bit, consumer accepts the result this cycle.

Function
REQ-013 SHALL compute the result as a logical right shift, res = data >> amt, with zero fill from the MSB side; amt = 0 passes data unchanged.
REQ-014 SHALL implement a single-entry result register controlled by a 2-state FSM: EMPTY (res_valid=0) and FULL (res_valid=1).
REQ-015 SHALL define can_accept = (state==EMPTY) or (res_valid and res_ready).
REQ-016 SHALL form grant combinationally from the valid inputs, the last-grant pointer and RR_EN; at most one grant per cycle.
REQ-017 SHALL set reqN_ready = can_accept and grant_N; ready is 0 for a requester that is not granted or not valid.
REQ-018 SHALL perform a transfer when reqN_valid and reqN_ready; on that edge it loads res_data with the shifted value, sets res_id=N and sets state to FULL.
REQ-019 SHALL have a latency of one cycle: res_valid rises on the edge after the cycle with the accepting handshake.
REQ-020 SHALL support full throughput: when FULL and res_ready=1, a new transfer on the same edge replaces the result with no bubble.
REQ-021 SHALL transition FULL -> EMPTY when res_ready=1 and no transfer occurs on that edge.
REQ-022 SHALL hold res_data, res_id and res_valid stable while res_valid=1 and res_ready=0, and drive both readys to 0 in that case.
REQ-023 SHALL, with RR_EN=1 and both requesters valid, grant the requester that is not the last-granted one; with one requester valid, it SHALL grant that requester.
REQ-024 SHALL update the last-grant pointer only on a completed transfer; a grant stalled by backpressure SHALL leave the pointer unchanged.
REQ-025 SHALL, with RR_EN=0, always grant req0 when req0_valid=1; the pointer is then ignored.
REQ-026 SHALL not lose or duplicate an operation; requesters SHALL hold valid, data and amt stable until ready, and the block SHALL not check this.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force state=EMPTY, res_valid=0, res_data=0x00, res_id=0 and last-grant pointer=1, so that req0 wins the first tie.
REQ-028 SHALL drop a result pending when reset is asserted mid-operation; no handshake completes in a cycle in which rst_n=0.
REQ-029 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Verification
REQ-030 SHALL be verified with req0 = 0xB5, amt 3, and res_ready=1 -> the next cycle shows res_valid=1, res_data=0x16, res_id=0.
REQ-031 SHALL be verified with the boundary amounts: 0xFF amt 7 -> 0x01, and 0x80 amt 0 -> 0x80.
REQ-032 SHALL be verified with both requesters continuously valid, RR_EN=1 and res_ready=1 -> res_id sequence 0,1,0,1 on consecutive cycles.
REQ-033 SHALL be verified with both requesters continuously valid and RR_EN=0 -> res_id is always 0 and req1_ready stays 0.
REQ-034 SHALL be verified with res_ready=0 for 3 cycles while FULL with 0x16 -> res_data holds 0x16, both readys are 0 and the pointer is unchanged; after res_ready=1, the next grant goes to the other requester.
REQ-035 SHALL be verified with rst_n pulsed low while FULL -> res_valid, res_data, res_id and the readys fall to 0 immediately, and after release the first tie grants req0.

Source files
------------

// File: rtl/shift_arbiter2.sv
// -----------------------------------------------------------------------------
// shift_arbiter2
//
// Two requesters share one logical right-shift unit (res = data >> amt, zero
// fill). A two-input arbiter selects one requester per cycle. Its result is
// captured in a single-entry result register with a valid/ready handshake
// toward the consumer.
//
// Parameters
//   RR_EN       1 = round-robin between the requesters,
//               0 = fixed priority, with req0 always winning
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   reqN_valid  requester N has an operation pending (N = 0, 1)
//   reqN_data   requester N operand, 8 bits
//   reqN_amt    requester N right-shift amount, 0..7
//   reqN_ready  requester N operation accepted this cycle
//   res_valid   result register holds a valid result
//   res_data    shifted result
//   res_id      requester that owns res_data
//   res_ready   consumer accepts the result this cycle
// -----------------------------------------------------------------------------
module shift_arbiter2 #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic [2:0] req0_amt,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic [2:0] req1_amt,
  output logic       req1_ready,
  output logic       res_valid,
  output logic [7:0] res_data,
  output logic       res_id,
  input  logic       res_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] data_q,  data_d;
  logic       id_q,    id_d;
  logic       last_q,  last_d;   // requester that won the last completed transfer

  logic       gnt0, gnt1;
  logic       can_accept;
  logic       xfer0, xfer1;
  logic [7:0] op_data;
  logic [2:0] op_amt;

  // ---------------------------------------------------------------------------
  // Arbitration. A tie in round-robin mode goes to the requester that did not
  // win last time. Only one grant can be active in any cycle.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven in an always_comb gets a default at the top of
  // the block, so no path can leave it unassigned and infer a latch.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (RR_EN) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end else begin
      gnt0 = req0_valid;
      gnt1 = req1_valid && !req0_valid;
    end
  end

  // The register can take a new result when it is empty, or when the current
  // result leaves on this same edge, which gives back-to-back transfers.
  assign can_accept = (state_q == EMPTY) || res_ready;

  // The readys are gated with rst_n. Reset forces the state to EMPTY, and
  // without the gate the readys would rise while reset is still held.
  assign req0_ready = rst_n && can_accept && gnt0;
  assign req1_ready = rst_n && can_accept && gnt1;

  assign xfer0 = req0_valid && req0_ready;
  assign xfer1 = req1_valid && req1_ready;

  assign op_data = xfer1 ? req1_data : req0_data;
  assign op_amt  = xfer1 ? req1_amt  : req0_amt;

  // ---------------------------------------------------------------------------
  // Next state of the result register and the last-grant pointer. The pointer
  // moves only on a completed transfer. A grant that is stalled by
  // backpressure does not change the pointer.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    last_d  = last_q;
    if (xfer0 || xfer1) begin
      state_d = FULL;
      data_d  = op_data >> op_amt;
      id_d    = xfer1;
      last_d  = xfer1;
    end else if ((state_q == FULL) && res_ready) begin
      state_d = EMPTY;
    end
  end

  // The pointer resets to 1, so req0 wins the first tie after reset.
  // NOTE: sequential state is assigned with non-blocking (<=) only, so every
  // register samples its pre-edge inputs whatever the evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= 8'h00;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  assign res_valid = (state_q == FULL);
  assign res_data  = data_q;
  assign res_id    = id_q;

endmodule

// File: tb/tb_shift_arbiter2.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter2
//
// Two instances of shift_arbiter2 are driven side by side. Index 0 runs with
// RR_EN=1 (round-robin) and index 1 runs with RR_EN=0 (fixed priority).
// A transaction-level model holds each instance's result register and
// last winner. Every negative edge compares all outputs of both instances
// against that model. Directed sequences pin the model with literal values,
// and a long randomized phase follows.
// -----------------------------------------------------------------------------
module tb_shift_arbiter2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b1;
  logic [1:0] v0, v1, rdy0, rdy1, rv, rid, rr;
  logic [7:0] d0 [2];
  logic [7:0] d1 [2];
  logic [7:0] rd [2];
  logic [2:0] a0 [2];
  logic [2:0] a1 [2];

  int errors = 0;
  int checks = 0;

  shift_arbiter2 #(.RR_EN(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0[0]), .req0_data(d0[0]), .req0_amt(a0[0]), .req0_ready(rdy0[0]),
    .req1_valid(v1[0]), .req1_data(d1[0]), .req1_amt(a1[0]), .req1_ready(rdy1[0]),
    .res_valid(rv[0]), .res_data(rd[0]), .res_id(rid[0]), .res_ready(rr[0])
  );

  shift_arbiter2 #(.RR_EN(1'b0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0[1]), .req0_data(d0[1]), .req0_amt(a0[1]), .req0_ready(rdy0[1]),
    .req1_valid(v1[1]), .req1_data(d1[1]), .req1_amt(a1[1]), .req1_ready(rdy1[1]),
    .res_valid(rv[1]), .res_data(rd[1]), .res_id(rid[1]), .res_ready(rr[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: per instance, the result held, its owner, and the
  // requester that won the last transfer.
  // ---------------------------------------------------------------------------
  logic       m_valid [2];
  logic [7:0] m_data  [2];
  logic       m_id    [2];
  logic       m_last  [2];

  // Winner among the valid requesters: -1 when none is valid.
  function automatic int pick(int k);
    if (v0[k] && v1[k]) begin
      if (k == 0) return m_last[k] ? 0 : 1;  // round-robin: not the last winner
      return 0;                              // fixed priority: req0
    end
    if (v0[k]) return 0;
    if (v1[k]) return 1;
    return -1;
  endfunction

  function automatic bit can_acc(int k);
    return !m_valid[k] || rr[k];
  endfunction

  function automatic bit exp_rdy(int k, int n);
    return rst_n && can_acc(k) && (pick(k) == n);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_valid[k] <= 1'b0;
        m_data[k]  <= 8'h00;
        m_id[k]    <= 1'b0;
        m_last[k]  <= 1'b1;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (can_acc(k) && pick(k) >= 0) begin
          m_valid[k] <= 1'b1;
          m_id[k]    <= (pick(k) == 1);
          m_last[k]  <= (pick(k) == 1);
          m_data[k]  <= (pick(k) == 1) ? (d1[k] >> a1[k]) : (d0[k] >> a0[k]);
        end else if (m_valid[k] && rr[k]) begin
          m_valid[k] <= 1'b0;
        end
      end
    end
  end

  // Compare process. It also records which requests are accepted on the
  // coming edge, so that the random driver can respect the hold-until-ready
  // rule.
  logic [1:0] acc0 = '0;
  logic [1:0] acc1 = '0;
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("res_valid[%0d]", k), 32'(rv[k]), 32'(m_valid[k]));
      check($sformatf("res_data[%0d]", k), 32'(rd[k]), 32'(m_data[k]));
      check($sformatf("res_id[%0d]", k), 32'(rid[k]), 32'(m_id[k]));
      check($sformatf("req0_ready[%0d]", k), 32'(rdy0[k]), 32'(exp_rdy(k, 0)));
      check($sformatf("req1_ready[%0d]", k), 32'(rdy1[k]), 32'(exp_rdy(k, 1)));
      acc0[k] <= v0[k] && exp_rdy(k, 0);
      acc1[k] <= v1[k] && exp_rdy(k, 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic va, input logic [7:0] da, input logic [2:0] aa,
                         input logic vb, input logic [7:0] db, input logic [2:0] ab);
    v0[k] = va; d0[k] = da; a0[k] = aa;
    v1[k] = vb; d1[k] = db; a1[k] = ab;
  endtask

  initial begin
    logic exp_id [4];
    exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
    rr = '0;
    for (int k = 0; k < 2; k++) set_req(k, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd0);

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("reset res_valid", 32'(rv[k]), 32'h0);
      check("reset res_data", 32'(rd[k]), 32'h00);
      check("reset res_id", 32'(rid[k]), 32'h0);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Basic shift, one-cycle latency, and boundary amounts
    tick();
    rr = 2'b11;
    for (int k = 0; k < 2; k++) set_req(k, 1'b1, 8'hB5, 3'd3, 1'b0, 8'h00, 3'd0);
    at_neg();
    check("B5 req0_ready", 32'(rdy0[0]), 32'h1);
    tick();
    for (int k = 0; k < 2; k++) set_req(k, 1'b1, 8'hFF, 3'd7, 1'b0, 8'h00, 3'd0);
    at_neg();
    check("B5>>3 valid", 32'(rv[0]), 32'h1);
    check("B5>>3 data", 32'(rd[0]), 32'h16);
    check("B5>>3 id", 32'(rid[0]), 32'h0);
    check("B5>>3 data fp", 32'(rd[1]), 32'h16);
    tick();
    for (int k = 0; k < 2; k++) set_req(k, 1'b1, 8'h80, 3'd0, 1'b0, 8'h00, 3'd0);
    at_neg();
    check("FF>>7 data", 32'(rd[0]), 32'h01);
    tick();
    for (int k = 0; k < 2; k++) set_req(k, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd0);
    at_neg();
    check("80>>0 data", 32'(rd[0]), 32'h80);
    at_neg();
    check("drained valid", 32'(rv[0]), 32'h0);

    // Reset while FULL, then a tie must go to req0, then alternate
    tick();
    rr = 2'b00;
    for (int k = 0; k < 2; k++) set_req(k, 1'b1, 8'hB5, 3'd3, 1'b1, 8'h22, 3'd0);
    tick();
    at_neg();
    check("pre-reset full", 32'(rv[0]), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("mid-reset res_valid", 32'(rv[k]), 32'h0);
      check("mid-reset res_data", 32'(rd[k]), 32'h00);
      check("mid-reset res_id", 32'(rid[k]), 32'h0);
      check("mid-reset req0_ready", 32'(rdy0[k]), 32'h0);
      check("mid-reset req1_ready", 32'(rdy1[k]), 32'h0);
    end
    rr = 2'b11;
    for (int k = 0; k < 2; k++) set_req(k, 1'b1, 8'h11, 3'd0, 1'b1, 8'h22, 3'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      at_neg();
      check("rr id seq", 32'(rid[0]), 32'(exp_id[i]));
      check("rr data seq", 32'(rd[0]), exp_id[i] ? 32'h22 : 32'h11);
      check("fp id", 32'(rid[1]), 32'h0);
      check("fp req1_ready", 32'(rdy1[1]), 32'h0);
    end

    // Backpressure: the result holds and the pointer stays put
    tick();
    for (int k = 0; k < 2; k++) set_req(k, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd0);
    tick();
    tick();
    set_req(0, 1'b1, 8'hB5, 3'd3, 1'b0, 8'h00, 3'd0);
    tick();
    set_req(0, 1'b1, 8'h33, 3'd1, 1'b1, 8'h20, 3'd0);
    rr[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      check("stall data", 32'(rd[0]), 32'h16);
      check("stall id", 32'(rid[0]), 32'h0);
      check("stall valid", 32'(rv[0]), 32'h1);
      check("stall req0_ready", 32'(rdy0[0]), 32'h0);
      check("stall req1_ready", 32'(rdy1[0]), 32'h0);
    end
    tick();
    rr[0] = 1'b1;
    at_neg();
    check("post-stall req1_ready", 32'(rdy1[0]), 32'h1);
    check("post-stall req0_ready", 32'(rdy0[0]), 32'h0);
    tick();
    set_req(0, 1'b1, 8'h33, 3'd1, 1'b0, 8'h00, 3'd0);
    at_neg();
    check("post-stall data", 32'(rd[0]), 32'h20);
    check("post-stall id", 32'(rid[0]), 32'h1);
    tick();
    set_req(0, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd0);
    at_neg();
    check("33>>1 data", 32'(rd[0]), 32'h19);

    // Randomized traffic, with each request held until it is accepted
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        rr[k] = ($urandom_range(0, 3) != 0);
        if (!v0[k] || acc0[k]) begin
          v0[k] = ($urandom_range(0, 2) != 0);
          d0[k] = 8'($urandom);
          a0[k] = 3'($urandom);
        end
        if (!v1[k] || acc1[k]) begin
          v1[k] = ($urandom_range(0, 2) != 0);
          d1[k] = 8'($urandom);
          a1[k] = 3'($urandom);
        end
      end
    end

    tick();
    at_neg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
